// File: rtl/idvr_div.sv
`default_nettype none
// ============================================================================
// Module   : idvr_div
// Brief    : Multi-cycle restoring divider (signed/unsigned quotient or
//            remainder), one shift-and-subtract step per clock, with a
//            START/BUSY/DONE handshake.
// Options  : IDVR_DIV_EARLY_EN - resolve divide-by-zero and signed overflow
//            on the START edge and report them one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module idvr_div #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] I0,
  input  logic [W-1:0] I1,
  input  logic [3:0]   S,
  input  logic         START,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] O
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   dvd_q, dvd_d;    // dividend magnitude, becomes quotient magnitude
  logic [W-1:0]   dvs_q, dvs_d;    // divisor magnitude
  logic [W-1:0]   rem_q, rem_d;    // partial remainder
  logic [W-1:0]   orig_q, orig_d;  // dividend as latched, for divide-by-zero remainder
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rsel_q, rsel_d;  // 1: remainder, 0: quotient
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic           dz_q, dz_d;
  logic           ovf_q, ovf_d;
  logic           done_q, done_d;
  logic [W-1:0]   o_q, o_d;

  logic           start_ok;
  logic           op_signed;
  logic           a_neg, b_neg;
  logic           is_dz, is_ovf;
  logic [W:0]     partial;
  logic [W:0]     diff;
  logic [W-1:0]   q_fix, r_fix;

  assign BUSY = (state_q != IDLE);
  assign DONE = done_q;
  assign O    = o_q;

  // Next-state, datapath step and result formation.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    orig_d  = orig_q;
    cnt_d   = cnt_q;
    rsel_d  = rsel_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    o_d     = o_q;

    start_ok  = START && (S[3:2] == 2'b01);
    op_signed = ~S[0];
    a_neg     = op_signed & I0[W-1];
    b_neg     = op_signed & I1[W-1];
    is_dz     = (I1 == '0);
    is_ovf    = op_signed && (I0 == {1'b1, {(W-1){1'b0}}}) && (I1 == {W{1'b1}});

    partial = {rem_q, dvd_q[W-1]};
    diff    = partial - {1'b0, dvs_q};

    q_fix = qneg_q ? (~dvd_q + 1'b1) : dvd_q;
    r_fix = rneg_q ? (~rem_q + 1'b1) : rem_q;
    if (dz_q) begin
      q_fix = {W{1'b1}};
      r_fix = orig_q;
    end else if (ovf_q) begin
      q_fix = {1'b1, {(W-1){1'b0}}};
      r_fix = '0;
    end

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          dvd_d   = a_neg ? (~I0 + 1'b1) : I0;
          dvs_d   = b_neg ? (~I1 + 1'b1) : I1;
          rem_d   = '0;
          orig_d  = I0;
          cnt_d   = CW'(W - 1);
          rsel_d  = S[1];
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = is_dz;
          ovf_d   = is_ovf;
`ifdef IDVR_DIV_EARLY_EN
          state_d = (is_dz || is_ovf) ? FIX : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        // Restoring step: keep the difference only when it did not borrow.
        dvd_d = {dvd_q[W-2:0], ~diff[W]};
        rem_d = diff[W] ? partial[W-1:0] : diff[W-1:0];
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        o_d     = rsel_q ? r_fix : q_fix;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      orig_q  <= '0;
      cnt_q   <= '0;
      rsel_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      orig_q  <= orig_d;
      cnt_q   <= cnt_d;
      rsel_q  <= rsel_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      o_q     <= o_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_idvr_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_idvr_div
// Brief    : Self-checking bench for idvr_div (W=32): directed operations with
//            literal results and latencies, plus a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idvr_div;

  localparam int W = 32;
  localparam int NORM_LAT = W + 1;
`ifdef IDVR_DIV_EARLY_EN
  localparam int SPEC_LAT = 1;
  localparam bit EARLY = 1'b1;
`else
  localparam int SPEC_LAT = W + 1;
  localparam bit EARLY = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] I0 = '0;
  logic [W-1:0] I1 = '0;
  logic [3:0]   S = '0;
  logic         START = 1'b0;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] O;

  int total = 0;
  int bad   = 0;

  idvr_div #(.W(W)) dut (
    .CLK(CLK), .RST(RST), .I0(I0), .I1(I1), .S(S),
    .START(START), .BUSY(BUSY), .DONE(DONE), .O(O)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: what the result must be, from the division rules.
  function automatic logic [W-1:0] ref_res(input logic [3:0] s, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] q, r;
    if (b == '0) begin
      q = '1; r = a;
    end else if (!s[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b; r = a % b;
    end
    return s[1] ? r : q;
  endfunction

  function automatic bit is_special(input logic [3:0] s, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
    return (b == '0) || (!s[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Cycle model: a countdown to the DONE edge, with a pending result.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_o = '0;
  logic [W-1:0] m_pend = '0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_left = 0; m_done = 1'b0; m_o = '0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_o    = m_pend;
        end
      end else if (START && S[3:2] == 2'b01) begin
        m_pend = ref_res(S, I0, I1);
        m_left = (EARLY && is_special(S, I0, I1)) ? 1 : NORM_LAT;
      end
    end
  end

  // Every-cycle comparison against the model, half a cycle after the edge.
  always @(negedge CLK) begin
    if (!RST) begin
      chk("model_busy", {31'd0, BUSY}, {31'd0, (m_left > 0)});
      chk("model_done", {31'd0, DONE}, {31'd0, m_done});
      chk("model_o", O, m_o);
    end
  end

  // Issue one operation, optionally poke a START while busy, and check the
  // result and the cycle on which DONE appears against literal values.
  task automatic run_op(input string name, input logic [3:0] s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_o,
                        input int exp_lat, input int poke_at);
    int lat;
    bit seen;
    @(negedge CLK);
    S = s; I0 = a; I1 = b; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge CLK); #1;
      lat++;
      if (DONE) begin
        seen = 1'b1;
      end else if (lat == poke_at) begin
        S = 4'b0101; I0 = 32'd9; I1 = 32'd3; START = 1'b1;
      end else begin
        START = 1'b0;
        I0 = 32'hDEAD_BEEF; I1 = 32'h1234_5678;
      end
    end
    START = 1'b0;
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_timeout actual=no_done required=done_by_%0d", name, exp_lat);
    end else begin
      chk({name, "_o"}, O, exp_o);
      chk({name, "_lat"}, lat, exp_lat);
    end
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_o", O, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Model pins.
    chk("pin_sq", ref_res(4'b0100, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("pin_sr", ref_res(4'b0110, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("pin_dz", ref_res(4'b0110, 32'hFFFF_FFF9, 32'd0), 32'hFFFF_FFF9);

    // Main function, back-to-back (each START lands in the previous DONE cycle).
    run_op("uq",    4'b0101, 32'd100,       32'd7,         32'd14,        NORM_LAT, -1);
    run_op("ur",    4'b0111, 32'd100,       32'd7,         32'd2,         NORM_LAT, -1);
    run_op("sq",    4'b0100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, NORM_LAT, -1);
    run_op("sr",    4'b0110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, NORM_LAT, -1);
    run_op("sq2",   4'b0100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, NORM_LAT, -1);
    run_op("sr2",   4'b0110, 32'd7,         32'hFFFF_FFFE, 32'd1,         NORM_LAT, -1);
    run_op("uqbig", 4'b0101, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, NORM_LAT, -1);

    // Divide by zero and signed overflow.
    run_op("dz_uq", 4'b0101, 32'd5,         32'd0,         32'hFFFF_FFFF, SPEC_LAT, -1);
    run_op("dz_ur", 4'b0111, 32'd5,         32'd0,         32'd5,         SPEC_LAT, -1);
    run_op("dz_sq", 4'b0100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, SPEC_LAT, -1);
    run_op("dz_sr", 4'b0110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, SPEC_LAT, -1);
    run_op("ov_sq", 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT, -1);
    run_op("ov_sr", 4'b0110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SPEC_LAT, -1);
    run_op("ov_uq", 4'b0101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         NORM_LAT, -1);

    // START while busy with different operands is ignored.
    run_op("poke",  4'b0101, 32'd1000,      32'd10,        32'd100,       NORM_LAT, 5);

    // START with a non-divide opcode in IDLE does nothing.
    @(negedge CLK);
    S = 4'b0000; I0 = 32'd50; I1 = 32'd5; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("badop_busy", {31'd0, BUSY}, 32'd0);
    repeat (40) @(posedge CLK);
    #1;
    chk("badop_done", {31'd0, DONE}, 32'd0);
    chk("badop_o", O, 32'd100);

    // Reset ten cycles into an operation aborts it immediately.
    @(negedge CLK);
    S = 4'b0101; I0 = 32'd200; I1 = 32'd3; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_done", {31'd0, DONE}, 32'd0);
    chk("abort_o", O, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (40) @(posedge CLK);
    #1;
    chk("abort_nodone", {31'd0, DONE}, 32'd0);
    chk("abort_idle", {31'd0, BUSY}, 32'd0);

    // Fresh operation after the abort.
    run_op("fresh", 4'b0101, 32'd100,       32'd7,         32'd14,        NORM_LAT, -1);
    repeat (3) @(posedge CLK);
    #1;
    chk("hold_o", O, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
